// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared types and constants for the data-memory port arbiter.
//   arb_state_t : arbiter FSM states (core service / steal armed / steal)
//   owner_t     : who drove the BRAM port in a given cycle
//   BRAM_RD_LAT : read latency of the data BRAM in clock cycles
//   is_active   : any byte enable set means an access this cycle
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

  localparam int BRAM_RD_LAT = 1;
  localparam int DATA_W      = 32;
  localparam int BE_W        = DATA_W / 8;
  localparam int CNT_W       = 8;  // wide enough for MAX_WAIT up to 255

  typedef enum logic [1:0] {
    S_CORE      = 2'd0,
    S_STEAL_ARM = 2'd1,
    S_STEAL     = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_EXT  = 2'd2
  } owner_t;

  function automatic logic is_active(input logic [BE_W-1:0] be);
    return |be;
  endfunction

endpackage : dmem_arb_pkg

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares the single data-BRAM port between the core memory stage and one
// external master (UART loader / debug DMA). The core has priority; the
// external master uses idle cycles, or after waiting MAX_WAIT busy cycles
// steals exactly one cycle while mem_hold freezes the core pipeline.
//
// Ports
//   clk, Rst                       clock, synchronous active-high reset
//   core_en/wea/addr/din           core memory-stage request
//   core_dout                      read data to core (shadowed across steals)
//   mem_hold                       registered pipeline freeze to the core
//   ext_req/we/be/addr/din         external request, held until ext_gnt
//   ext_gnt                        external request accepted (combinational)
//   ext_rvalid, ext_dout           external read return, BRAM_RD_LAT later
//   mem_en/wea/addr/din, mem_dout  BRAM port
// -----------------------------------------------------------------------------
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 15,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              Rst,

  input  logic [BE_W-1:0]   core_en,
  input  logic              core_wea,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_din,
  output logic [DATA_W-1:0] core_dout,
  output logic              mem_hold,

  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [BE_W-1:0]   ext_be,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_din,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_dout,

  output logic [BE_W-1:0]   mem_en,
  output logic              mem_wea,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam logic [CNT_W-1:0] MAX_WAIT_C = CNT_W'(MAX_WAIT);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  arb_state_t              state;
  arb_state_t              state_d;
  owner_t                  owner_q;    // who drove the port last cycle
  owner_t                  sel;        // who drives the port this cycle
  logic [CNT_W-1:0]        wait_cnt;   // busy cycles the pending ext request has waited
  logic [DATA_W-1:0]       shadow;     // last read data delivered to the core
  logic [DATA_W-1:0]       ext_dout_q; // last read data delivered to the ext master
  logic [BRAM_RD_LAT-1:0]  rd_pipe;    // ext read issued, aligned to BRAM latency

  logic core_active;
  logic at_limit;
  logic rd_issue;

  assign core_active = is_active(core_en);
  assign at_limit    = (wait_cnt == MAX_WAIT_C);
  assign rd_issue    = ext_gnt && !ext_we;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: every clocked block uses non-blocking assignments so all registers
  // update from the same pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (Rst) state <= S_CORE;
    else     state <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: each combinational block assigns a default to every output first,
  // so no path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_d = state;
    unique case (state)
      // The core keeps the port this cycle; the steal happens two cycles on,
      // leaving one cycle to register mem_hold.
      S_CORE:      if (core_active && ext_req && at_limit) state_d = S_STEAL_ARM;
      S_STEAL_ARM: state_d = S_STEAL;
      S_STEAL:     state_d = S_CORE;
      default:     state_d = S_CORE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: output logic (port owner and external grant)
  // ---------------------------------------------------------------------------
  always_comb begin
    sel     = OWN_NONE;
    ext_gnt = 1'b0;
    if (!Rst) begin
      unique case (state)
        S_CORE: begin
          if (core_active) begin
            sel = OWN_CORE;
          end else if (ext_req) begin
            // Idle slot: core_active gates the grant, so the two never collide.
            sel     = OWN_EXT;
            ext_gnt = 1'b1;
          end
        end
        S_STEAL_ARM: begin
          if (core_active) sel = OWN_CORE;
        end
        S_STEAL: begin
          // A request withdrawn before its steal leaves the port quiet.
          if (ext_req) begin
            sel     = OWN_EXT;
            ext_gnt = 1'b1;
          end
        end
        default: begin
          sel     = OWN_NONE;
          ext_gnt = 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // BRAM port mux
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_en   = '0;
    mem_wea  = 1'b0;
    mem_addr = '0;
    mem_din  = '0;
    unique case (sel)
      OWN_CORE: begin
        mem_en   = core_en;
        mem_wea  = core_wea;
        mem_addr = core_addr;
        mem_din  = core_din;
      end
      OWN_EXT: begin
        mem_en   = ext_be;
        mem_wea  = ext_we;
        mem_addr = ext_addr;
        mem_din  = ext_din;
      end
      default: begin
        mem_en   = '0;
        mem_wea  = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Wait counter: counts busy cycles seen by a pending external request.
  // Cleared on any grant, so after a steal the core gets MAX_WAIT+1 cycles
  // before the next one.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (Rst) begin
      wait_cnt <= '0;
    end else if (ext_gnt || state == S_STEAL || !ext_req) begin
      wait_cnt <= '0;
    end else if (state == S_CORE && core_active && !at_limit) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Pipeline freeze: raised for exactly the steal cycle. Driven from a
  // register so the core sees a clean, glitch-free hold.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (Rst) mem_hold <= 1'b0;
    else     mem_hold <= (state == S_STEAL_ARM);
  end

  // ---------------------------------------------------------------------------
  // Read-data return paths
  // ---------------------------------------------------------------------------
  // NOTE: the data-holding registers (shadow, ext_dout_q) are reset as well so
  // both read buses show a known zero before the first access.
  always_ff @(posedge clk) begin
    if (Rst) begin
      owner_q    <= OWN_CORE;
      shadow     <= '0;
      ext_dout_q <= '0;
      rd_pipe    <= '0;
    end else begin
      owner_q <= sel;
      rd_pipe <= BRAM_RD_LAT'({rd_pipe, rd_issue});
      if (owner_q == OWN_CORE) shadow     <= mem_dout;
      if (ext_rvalid)          ext_dout_q <= mem_dout;
    end
  end

  assign ext_rvalid = rd_pipe[BRAM_RD_LAT-1];

  // The BRAM output belongs to whoever owned the port last cycle. When that
  // was not the core, the stalled memory stage keeps seeing its last word.
  assign core_dout = (owner_q == OWN_CORE) ? mem_dout : shadow;

  // Live BRAM data in the valid cycle, held afterwards.
  assign ext_dout  = ext_rvalid ? mem_dout : ext_dout_q;

endmodule : dmem_arbiter

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter with MAX_WAIT=3 and a 1-cycle BRAM model.
// Inputs change 1 time unit after the rising edge; outputs are checked on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
  import dmem_arb_pkg::*;

  localparam int ADDR_W = 32;
  localparam int MAX_W  = 3;

  logic              clk;
  logic              rst;
  logic [3:0]        core_en;
  logic              core_wea;
  logic [ADDR_W-1:0] core_addr;
  logic [31:0]       core_din;
  logic [31:0]       core_dout;
  logic              mem_hold;
  logic              ext_req;
  logic              ext_we;
  logic [3:0]        ext_be;
  logic [ADDR_W-1:0] ext_addr;
  logic [31:0]       ext_din;
  logic              ext_gnt;
  logic              ext_rvalid;
  logic [31:0]       ext_dout;
  logic [3:0]        mem_en;
  logic              mem_wea;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic [31:0]       mem_dout;

  int checks = 0;
  int errors = 0;

  logic [31:0] bram [0:255];

  dmem_arbiter #(.MAX_WAIT(MAX_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .Rst        (rst),
    .core_en    (core_en),
    .core_wea   (core_wea),
    .core_addr  (core_addr),
    .core_din   (core_din),
    .core_dout  (core_dout),
    .mem_hold   (mem_hold),
    .ext_req    (ext_req),
    .ext_we     (ext_we),
    .ext_be     (ext_be),
    .ext_addr   (ext_addr),
    .ext_din    (ext_din),
    .ext_gnt    (ext_gnt),
    .ext_rvalid (ext_rvalid),
    .ext_dout   (ext_dout),
    .mem_en     (mem_en),
    .mem_wea    (mem_wea),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read-first BRAM, 1-cycle latency, byte-lane writes.
  always @(posedge clk) begin
    if (|mem_en) begin
      mem_dout <= bram[mem_addr[9:2]];
      if (mem_wea) begin
        for (int b = 0; b < 4; b++)
          if (mem_en[b]) bram[mem_addr[9:2]][8*b +: 8] <= mem_din[8*b +: 8];
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic all_idle();
    core_en = 4'h0; core_wea = 1'b0; core_addr = '0; core_din = '0;
    ext_req = 1'b0; ext_we = 1'b0; ext_be = 4'h0; ext_addr = '0; ext_din = '0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    core_en = 4'hF; core_wea = 1'b1; core_addr = 32'h10; core_din = 32'hFFFF_FFFF;
    ext_req = 1'b1; ext_we = 1'b1; ext_be = 4'hF; ext_addr = 32'h40; ext_din = 32'h1;
    next_cycle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (mem_hold !== 1'b0) begin errors++; $display("FAIL reset_mem_hold cyc %0d got %b exp 0", c, mem_hold); end
      checks++;
      if (ext_gnt !== 1'b0) begin errors++; $display("FAIL reset_ext_gnt cyc %0d got %b exp 0", c, ext_gnt); end
      checks++;
      if (mem_en !== 4'h0) begin errors++; $display("FAIL reset_mem_en cyc %0d got %h exp 0", c, mem_en); end
      checks++;
      if (ext_rvalid !== 1'b0) begin errors++; $display("FAIL reset_ext_rvalid cyc %0d got %b exp 0", c, ext_rvalid); end
      next_cycle();
    end
    rst = 1'b0;
    all_idle();
    core_en = 4'hF; core_addr = 32'h10;
    @(negedge clk);
    checks++;
    if (mem_addr !== 32'h10) begin errors++; $display("FAIL release_mem_addr got %h exp 00000010", mem_addr); end
    checks++;
    if (mem_en !== 4'hF) begin errors++; $display("FAIL release_mem_en got %h exp f", mem_en); end
    next_cycle();
    all_idle();
    next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_idle_read();
    all_idle();
    ext_req = 1'b1; ext_we = 1'b0; ext_be = 4'hF; ext_addr = 32'h40;
    @(negedge clk);
    checks++;
    if (ext_gnt !== 1'b1) begin errors++; $display("FAIL idle_gnt got %b exp 1", ext_gnt); end
    checks++;
    if (mem_addr !== 32'h40 || mem_en !== 4'hF || mem_wea !== 1'b0) begin
      errors++; $display("FAIL idle_port got addr %h en %h wea %b exp 00000040 f 0", mem_addr, mem_en, mem_wea);
    end
    checks++;
    if (mem_hold !== 1'b0) begin errors++; $display("FAIL idle_hold0 got %b exp 0", mem_hold); end
    next_cycle();
    all_idle();
    @(negedge clk);
    checks++;
    if (ext_rvalid !== 1'b1) begin errors++; $display("FAIL idle_rvalid got %b exp 1", ext_rvalid); end
    checks++;
    if (ext_dout !== 32'hDEAD_BEEF) begin errors++; $display("FAIL idle_dout got %h exp deadbeef", ext_dout); end
    checks++;
    if (mem_hold !== 1'b0) begin errors++; $display("FAIL idle_hold1 got %b exp 0", mem_hold); end
    next_cycle();
    @(negedge clk);
    checks++;
    if (ext_rvalid !== 1'b0) begin errors++; $display("FAIL idle_rvalid_pulse got %b exp 0", ext_rvalid); end
    next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_steal_write();
    all_idle();
    core_en = 4'hF; core_addr = 32'h100;
    ext_req = 1'b1; ext_we = 1'b1; ext_be = 4'hF; ext_addr = 32'h80; ext_din = 32'h1234_5678;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      checks++;
      if (ext_gnt !== 1'b0 || mem_hold !== 1'b0 || mem_addr !== 32'h100) begin
        errors++;
        $display("FAIL steal_wait cyc %0d got gnt %b hold %b addr %h exp 0 0 00000100", c, ext_gnt, mem_hold, mem_addr);
      end
      if (c == 4) begin
        checks++;
        if (dut.state !== S_STEAL_ARM) begin errors++; $display("FAIL steal_arm_state got %0d exp %0d", dut.state, S_STEAL_ARM); end
      end
      next_cycle();
    end
    @(negedge clk);
    checks++;
    if (mem_hold !== 1'b1 || ext_gnt !== 1'b1) begin
      errors++; $display("FAIL steal_cycle got hold %b gnt %b exp 1 1", mem_hold, ext_gnt);
    end
    checks++;
    if (mem_wea !== 1'b1 || mem_addr !== 32'h80 || mem_din !== 32'h1234_5678 || mem_en !== 4'hF) begin
      errors++; $display("FAIL steal_port got wea %b addr %h din %h en %h exp 1 00000080 12345678 f", mem_wea, mem_addr, mem_din, mem_en);
    end
    next_cycle();
    ext_req = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_hold !== 1'b0 || ext_gnt !== 1'b0 || ext_rvalid !== 1'b0) begin
      errors++; $display("FAIL steal_after got hold %b gnt %b rvalid %b exp 0 0 0", mem_hold, ext_gnt, ext_rvalid);
    end
    checks++;
    if (mem_addr !== 32'h100 || mem_en !== 4'hF) begin
      errors++; $display("FAIL steal_core_resume got addr %h en %h exp 00000100 f", mem_addr, mem_en);
    end
    checks++;
    if (bram[32] !== 32'h1234_5678) begin errors++; $display("FAIL steal_bram got %h exp 12345678", bram[32]); end
    next_cycle();
    all_idle();
    next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_shadow();
    all_idle();
    core_en = 4'hF; core_addr = 32'h20;
    ext_req = 1'b1; ext_we = 1'b0; ext_be = 4'hF; ext_addr = 32'h24;
    for (int c = 0; c < 5; c++) next_cycle();
    @(negedge clk);
    checks++;
    if (mem_hold !== 1'b1 || mem_addr !== 32'h24) begin
      errors++; $display("FAIL shadow_steal got hold %b addr %h exp 1 00000024", mem_hold, mem_addr);
    end
    checks++;
    if (core_dout !== 32'hA5A5_A5A5) begin errors++; $display("FAIL shadow_hold_cycle got %h exp a5a5a5a5", core_dout); end
    next_cycle();
    ext_req = 1'b0;
    @(negedge clk);
    checks++;
    if (core_dout !== 32'hA5A5_A5A5) begin errors++; $display("FAIL shadow_after_cycle got %h exp a5a5a5a5", core_dout); end
    checks++;
    if (ext_rvalid !== 1'b1 || ext_dout !== 32'h5A5A_5A5A) begin
      errors++; $display("FAIL shadow_ext_read got rvalid %b dout %h exp 1 5a5a5a5a", ext_rvalid, ext_dout);
    end
    checks++;
    if (mem_hold !== 1'b0) begin errors++; $display("FAIL shadow_hold_drop got %b exp 0", mem_hold); end
    next_cycle();
    all_idle();
    next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_fairness();
    int grants;
    int g0;
    int g1;
    int holds;
    int hold_no_gnt;
    grants = 0; g0 = -1; g1 = -1; holds = 0; hold_no_gnt = 0;
    all_idle();
    core_en = 4'hF; core_addr = 32'h100;
    ext_req = 1'b1; ext_we = 1'b1; ext_be = 4'hF; ext_addr = 32'h84; ext_din = 32'h0000_0001;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (ext_gnt === 1'b1) begin
        if (grants == 0) g0 = c;
        else if (grants == 1) g1 = c;
        grants++;
      end
      if (mem_hold === 1'b1) holds++;
      if (mem_hold === 1'b1 && ext_gnt !== 1'b1) hold_no_gnt++;
      next_cycle();
    end
    all_idle();
    checks++;
    if (grants != 2) begin errors++; $display("FAIL fair_grant_count got %0d exp 2", grants); end
    checks++;
    if (g0 != 5 || g1 != 11) begin errors++; $display("FAIL fair_grant_cycles got %0d %0d exp 5 11", g0, g1); end
    checks++;
    if (g1 - g0 < 5) begin errors++; $display("FAIL fair_spacing got %0d exp >=5", g1 - g0); end
    checks++;
    if (holds != 2 || hold_no_gnt != 0) begin
      errors++; $display("FAIL fair_holds got %0d (unmatched %0d) exp 2 (0)", holds, hold_no_gnt);
    end
    next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_rst_mid_steal();
    all_idle();
    core_en = 4'hF; core_addr = 32'h100;
    ext_req = 1'b1; ext_we = 1'b0; ext_be = 4'hF; ext_addr = 32'h24;
    for (int c = 0; c < 5; c++) next_cycle();
    @(negedge clk);
    checks++;
    if (mem_hold !== 1'b1) begin errors++; $display("FAIL rst_steal_reached got %b exp 1", mem_hold); end
    rst = 1'b1;
    #1;
    checks++;
    if (ext_gnt !== 1'b0 || mem_en !== 4'h0) begin
      errors++; $display("FAIL rst_gate got gnt %b en %h exp 0 0", ext_gnt, mem_en);
    end
    next_cycle();
    rst = 1'b0;
    all_idle();
    @(negedge clk);
    checks++;
    if (mem_hold !== 1'b0 || ext_rvalid !== 1'b0) begin
      errors++; $display("FAIL rst_outputs got hold %b rvalid %b exp 0 0", mem_hold, ext_rvalid);
    end
    checks++;
    if (dut.state !== S_CORE || dut.wait_cnt !== 8'd0) begin
      errors++; $display("FAIL rst_state got state %0d wait %0d exp %0d 0", dut.state, dut.wait_cnt, S_CORE);
    end
    next_cycle();
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < 256; i++) bram[i] = 32'h0;
    bram[16] = 32'hDEAD_BEEF;  // 0x40
    bram[8]  = 32'hA5A5_A5A5;  // 0x20
    bram[9]  = 32'h5A5A_5A5A;  // 0x24
    mem_dout = 32'h0;
    test_reset();
    test_idle_read();
    test_steal_write();
    test_shadow();
    test_fairness();
    test_rst_mid_steal();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_dmem_arbiter

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between the core's memory stage and one external master (UART loader / debug DMA).
- Sits between the core memory-stage outputs (mem_en/mem_wea/mem_addr/mem_din) and the data BRAM.
- The core has priority. The external master uses idle cycles, or steals one cycle after a bounded wait by asserting mem_hold to freeze the pipeline.
- Keeps core read data stable across stolen cycles.

Parameters:
- MAX_WAIT, 15, cycles an external request may wait while the core is busy before a steal is forced (1..255).
- ADDR_W, 32, address width on all ports.

Ports:
- clk  in  1  system clock
- Rst  in  1  synchronous active-high reset
- core_en  in  4  core byte enables; any bit set = core access this cycle
- core_wea  in  1  core write strobe
- core_addr  in  ADDR_W  core byte address
- core_din  in  32  core write data
- core_dout  out  32  read data returned to core memory stage
- mem_hold  out  1  pipeline freeze to core (registered)
- ext_req  in  1  external access request; held until ext_gnt
- ext_we  in  1  1 = write, 0 = read
- ext_be  in  4  external byte enables
- ext_addr  in  ADDR_W  external address
- ext_din  in  32  external write data
- ext_gnt  out  1  external request accepted this cycle (combinational)
- ext_rvalid  out  1  external read data valid
- ext_dout  out  32  external read data
- mem_en  out  4  BRAM byte enables
- mem_wea  out  1  BRAM write strobe
- mem_addr  out  ADDR_W  BRAM address
- mem_din  out  32  BRAM write data
- mem_dout  in  32  BRAM read data, fixed 1-cycle latency

Behaviour:
- Clocking and reset: single clock domain; reset synchronous active-high on clk.
- Reset values: mem_hold=0, ext_rvalid=0, ext_dout=0, wait_cnt=0, shadow=0, owner_q=CORE, state=S_CORE.
  - ext_gnt and mem_* are combinational; they are 0 in reset cycles.
- FSM states: S_CORE, S_STEAL_ARM, S_STEAL.
- S_CORE:
  - If core_active (|core_en) is set: mem_* = core signals, ext_gnt=0.
    - wait_cnt increments while ext_req is set, saturating at MAX_WAIT.
  - If core_active=0 and ext_req=1: idle-slot grant. mem_* = ext signals (mem_en=ext_be, mem_wea=ext_we), ext_gnt=1, wait_cnt cleared, no hold.
  - If core_active=1, ext_req=1 and wait_cnt==MAX_WAIT: the core is still served this cycle; go to S_STEAL_ARM.
- S_STEAL_ARM:
  - Core still served; mem_hold register set to 1 for the next cycle.
  - Go to S_STEAL.
  - Adds exactly one core access between decision and steal, so mem_hold stays registered.
- S_STEAL:
  - mem_hold=1, port driven by ext, ext_gnt=1, wait_cnt cleared.
  - Next state S_CORE; mem_hold clears on the next edge.
  - The core re-presents its frozen request in the following cycle.
  - If ext_req has dropped (protocol violation), mem_en=0 and ext_gnt=0; state still returns to S_CORE.
- owner_q: registers who drove the port last cycle (CORE, EXT, NONE).
- ext read return: ext_rvalid pulses 1 cycle after a granted read, with ext_dout = mem_dout. No pulse for writes.
- core_dout:
  - owner_q==CORE: core_dout = mem_dout, and shadow <= mem_dout.
  - Otherwise: core_dout = shadow, so the stalled memory stage sees stable data.
- Back-to-back external requests: at most one external grant per cycle.
  - After a steal, the core is guaranteed at least MAX_WAIT+1 cycles before the next steal (counter restarts at 0).
- Simultaneous core and external access in an idle-slot cycle cannot occur; core_active gates the grant combinationally.
- Reset mid-steal: all state returns to reset values the next edge; mem_hold drops; any pending ext_rvalid is discarded.

Decomposition:
- Package dmem_arb_pkg holds:
  - typedef enum arb_state_t {S_CORE, S_STEAL_ARM, S_STEAL}
  - typedef enum owner_t {OWN_NONE, OWN_CORE, OWN_EXT}
  - localparam BRAM_RD_LAT=1
- No sub-module is required. The wait counter and shadow register are small enough to remain inline.

Test Plan:
- Reset: Rst=1 for 3 cycles, all inputs active -> mem_hold=0, ext_gnt=0, mem_en=0, ext_rvalid=0; after release, core_en=4'hF, addr 0x10 -> mem_addr=0x10 same cycle.
- Idle-slot read: core_en=0, ext_req=1, ext_we=0, ext_addr=0x40, BRAM[0x40]=0xDEADBEEF -> ext_gnt=1 that cycle; ext_rvalid=1 and ext_dout=0xDEADBEEF next cycle; mem_hold stays 0.
- Starvation steal, MAX_WAIT=3: core_en=4'hF continuously, ext_req=1 write 0x12345678 to 0x80 -> ext_gnt=0 for 4 cycles, then S_STEAL_ARM. mem_hold=1 for exactly one cycle with ext_gnt=1 and mem_wea=1, mem_addr=0x80. BRAM[0x80]=0x12345678 afterwards.
- Shadow stability: core reads 0x20 (=0xA5A5A5A5) in the S_STEAL_ARM cycle; ext reads 0x24 (=0x5A5A5A5A) in the steal -> core_dout=0xA5A5A5A5 for both the hold cycle and the cycle after; ext_dout=0x5A5A5A5A.
- Fairness: ext_req held high through two transfers with core busy, MAX_WAIT=3 -> grants separated by ≥5 cycles; core sees exactly one mem_hold cycle per steal.
- Reset mid-steal: assert Rst in the mem_hold=1 cycle -> next cycle mem_hold=0, ext_rvalid=0, state S_CORE, wait_cnt=0.
